top_cash: RTL and testbench
===========================

TOP_CASH -- requirements
Module: top_cash

Interface
REQ-001 clk  input  1  single system clock; all state updates on the rising edge.
REQ-002 reset_neg  input  1  reset is asynchronous and active-low.
REQ-003 address  input  32  word address; only bits [9:0] are used, bits [31:10] are ignored.
REQ-004 write_data  input  32  data for a write request.
REQ-005 write_en  input  1  write request; level-sensitive, held until stall drops.
REQ-006 read_en  input  1  read request; level-sensitive, held until stall drops.
REQ-007 stall  output  1  high while the current request is not complete.
REQ-008 read_data  output  32  read result; valid when read_en=1 and stall=0.
REQ-009 Parameter MEM_LATENCY, default 4: main-memory access cycles.
REQ-010 Parameter BLOCK_WORDS, default 4: words per cache line.

Function
REQ-011 The block SHALL contain a main memory of 1024 x 32 bits, indexed by address[9:0].
REQ-012 The block SHALL contain a direct-mapped cache of 32 lines x 4 words, with a valid bit and a 3-bit tag per line.
REQ-013 Address fields SHALL be: offset = address[1:0], index = address[6:2], tag = address[9:7].
REQ-014 Hit SHALL be defined as valid[index]=1 and tag[index]=address[9:7].
REQ-015 The controller SHALL be an FSM with states IDLE, READ_MISS and WRITE.
REQ-016 In IDLE, write_en=1 SHALL go to WRITE; this takes priority over read_en.
REQ-017 In IDLE, read_en=1 with write_en=0 and a miss SHALL go to READ_MISS.
REQ-018 In IDLE, a read hit SHALL stay in IDLE with stall=0 (zero-cycle latency).
REQ-019 In IDLE with no request, the FSM SHALL stay in IDLE with stall=0.
REQ-020 stall SHALL be combinational: high in IDLE when a write or read-miss request is present, and high in READ_MISS and WRITE.
REQ-021 A 2-bit access counter SHALL count MEM_LATENCY cycles in READ_MISS and WRITE, then return to IDLE.
REQ-022 A write or read-miss request SHALL therefore hold stall for 5 cycles (1 IDLE + 4 access) before it drops.
REQ-023 WRITE behaviour:
- Write-through.
- On the final access cycle, mem[address[9:0]] <= write_data.
- On a hit, the cache word is also updated on that edge.
REQ-024 Write miss SHALL be no-write-allocate: valid and tag are unchanged.
REQ-025 READ_MISS behaviour: on the final access cycle, all 4 words of the aligned block (address[9:2], offsets 0..3) SHALL be loaded from memory, tag written, valid set.
REQ-026 After a READ_MISS, the request SHALL be a hit in IDLE, so stall drops and the data appears.
REQ-027 read_data SHALL equal the cache word at index/offset when read_en=1 and hit; otherwise it SHALL be 0.
REQ-028 address, write_data, write_en and read_en SHALL be sampled continuously; the requester holds them stable while stall=1.
REQ-029 Changing inputs during stall is undefined; the implementation uses the inputs present on the final access edge.
REQ-030 Main memory SHALL be modified only on the final WRITE access cycle.

Reset
REQ-031 reset_neg=0 SHALL asynchronously force: FSM to IDLE, access counter to 0, all valid bits to 0.
REQ-032 During reset, stall SHALL be 0 and read_data SHALL be 0.
REQ-033 Reset mid-access SHALL abort the access: no memory or cache update; no partial line becomes valid.
REQ-034 Main memory and cache data arrays SHALL NOT be cleared by reset; their contents persist across reset.
REQ-035 After reset is released, the first request SHALL start in IDLE on the next rising edge.

Verification
REQ-036 Reset with write_en=1 held:
- stall=0 and no memory change while reset_neg=0.
- After release, stall is high for 5 cycles.
REQ-037 Write misses 128<-1, 129<-2, 130<-3, 131<-4 (5 stall cycles each):
- mem holds 1..4.
- Cache line 0 stays invalid (no-write-allocate).
REQ-038 Read 128 after REQ-037:
- Miss with 5 stall cycles.
- Then stall=0 and read_data=1.
REQ-039 Read 129, 130, 131 after REQ-038:
- Immediate hits with stall=0.
- read_data = 2, 3, 4 respectively.
REQ-040 Write hit 130<-15:
- 5 stall cycles.
- Then read 130 is a hit with stall=0, read_data=15, and mem[130]=15.
REQ-041 Assert reset_neg=0 during the 3rd access cycle of a write to 200:
- mem[200] is unchanged.
- FSM is IDLE.
- Then read 128 is a miss (valid cleared).

Source files
------------

// File: rtl/top_cash.sv
// rtl/top_cash.sv - direct-mapped write-through cache in front of a 1024x32 main memory
//
// Purpose: 32-line x 4-word direct-mapped cache with a 3-bit tag and a valid bit per
// line, backed by a 1024-word main memory. Write-through, no-write-allocate. Read
// hits complete with zero latency. Read misses and writes take MEM_LATENCY access
// cycles after the cycle in which the request is seen in IDLE.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_neg  - asynchronous active-low reset (FSM, access counter, valid bits)
//   address    - word address; only [9:0] is used
//   write_data - data for a write request
//   write_en   - write request, held by the requester until the access completes
//   read_en    - read request, held by the requester until stall drops
//   stall      - high while the current request is not complete
//   read_data  - cache word on a read hit, otherwise 0
module top_cash #(
  parameter int MEM_LATENCY = 4,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset_neg,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_en,
  input  logic        read_en,
  output logic        stall,
  output logic [31:0] read_data
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_t;

  localparam logic [1:0] LAST = 2'(MEM_LATENCY - 1);

  state_t      state;
  state_t      state_next;
  logic [1:0]  cnt;
  logic [31:0] valid;
  logic [2:0]  tags [0:31];
  logic [31:0] cache_data [0:31][0:3];
  logic [31:0] mem [0:1023];

  logic [1:0]  offset;
  logic [4:0]  index;
  logic [2:0]  tag;
  logic        hit;
  logic        last_access;

  assign offset      = address[1:0];
  assign index       = address[6:2];
  assign tag         = address[9:7];
  assign hit         = valid[index] && (tags[index] == tag);
  assign last_access = (state != IDLE) && (cnt == LAST);

  // Next state and stall. Stall is forced low during reset so a requester
  // holding write_en while reset is asserted sees no stall.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (write_en) begin
          state_next = WRITE;
          stall      = 1'b1;
        end else if (read_en && !hit) begin
          state_next = READ_MISS;
          stall      = 1'b1;
        end
      end
      READ_MISS, WRITE: begin
        stall = 1'b1;
        if (cnt == LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!reset_neg) stall = 1'b0;
  end

  assign read_data = (reset_neg && read_en && hit) ? cache_data[index][offset] : 32'd0;

  // Control state: cleared asynchronously, so an access in flight is abandoned
  // and the line it was filling never becomes valid.
  always_ff @(posedge clk or negedge reset_neg) begin
    if (!reset_neg) begin
      state <= IDLE;
      cnt   <= 2'd0;
      valid <= 32'd0;
    end else begin
      state <= state_next;
      if (state == IDLE || last_access) cnt <= 2'd0;
      else                              cnt <= cnt + 2'd1;
      if (state == READ_MISS && last_access) valid[index] <= 1'b1;
    end
  end

  // Storage arrays keep their contents across reset. The reset_neg guard keeps
  // an edge that coincides with reset from committing anything.
  always_ff @(posedge clk) begin
    if (reset_neg && last_access) begin
      if (state == WRITE) begin
        mem[address[9:0]] <= write_data;
        if (hit) cache_data[index][offset] <= write_data;
      end else if (state == READ_MISS) begin
        tags[index] <= tag;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
          cache_data[index][i] <= mem[{address[9:2], 2'(i)}];
        end
      end
    end
  end

endmodule

// File: tb/tb_top_cash.sv
// tb/tb_top_cash.sv - scoreboard testbench for top_cash
module tb_top_cash;

  logic        clk = 1'b0;
  logic        reset_neg;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_en;
  logic        read_en;
  logic        stall;
  logic [31:0] read_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  int   mon_stalls = 0;

  top_cash dut (
    .clk        (clk),
    .reset_neg  (reset_neg),
    .address    (address),
    .write_data (write_data),
    .write_en   (write_en),
    .read_en    (read_en),
    .stall      (stall),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, req, req);
    end
  endtask

  // Monitor: counts stall cycles of a held read and, when the read completes
  // (read_en=1, stall=0), pops the expected response and compares.
  always @(negedge clk) begin
    if (reset_neg && read_en) begin
      if (stall) begin
        mon_stalls++;
      end else begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: data %0d with no expected entry", read_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("read_data", read_data, e.data);
          check("read_stalls", 32'(mon_stalls), 32'(e.stalls));
        end
        mon_stalls = 0;
      end
    end
  end

  // Requests are already presented; expects five stall cycles, then drops
  // write_en right after the committing edge and checks the FSM is idle.
  task automatic finish_write(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (stall) n++;
      @(posedge clk);
    end
    #1 write_en = 1'b0;
    check({name, "_stalls"}, 32'(n), 32'd5);
    @(negedge clk);
    check({name, "_idle"}, {31'd0, stall}, 32'd0);
  endtask

  task automatic do_write(input string name, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    address    = a;
    write_data = d;
    write_en   = 1'b1;
    finish_write(name);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int stalls);
    bit done;
    exp_q.push_back('{data: d, stalls: stalls});
    @(posedge clk);
    #1;
    address = a;
    read_en = 1'b1;
    done    = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL read_timeout: stall still %0d at address %0d, expected 0", stall, a);
    end
    @(posedge clk);
    #1 read_en = 1'b0;
  endtask

  initial begin
    // Reset held with a write request present.
    reset_neg  = 1'b0;
    address    = 32'd300;
    write_data = 32'h55;
    write_en   = 1'b1;
    read_en    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_read_data", read_data, 32'd0);
    check("reset_state", 32'(dut.state), 32'd0);
    check("reset_cnt", 32'(dut.cnt), 32'd0);
    @(posedge clk);
    #1 reset_neg = 1'b1;
    finish_write("post_reset_write");
    check("mem300", dut.mem[300], 32'h55);

    // Write misses: no-write-allocate.
    do_write("wr128", 32'd128, 32'd1);
    do_write("wr129", 32'd129, 32'd2);
    do_write("wr130", 32'd130, 32'd3);
    do_write("wr131", 32'd131, 32'd4);
    check("mem128", dut.mem[128], 32'd1);
    check("mem129", dut.mem[129], 32'd2);
    check("mem130", dut.mem[130], 32'd3);
    check("mem131", dut.mem[131], 32'd4);
    check("line0_invalid", {31'd0, dut.valid[0]}, 32'd0);

    // Read miss refills the line; the rest of the block then hits.
    do_read(32'd128, 32'd1, 5);
    do_read(32'd129, 32'd2, 0);
    do_read(32'd130, 32'd3, 0);
    do_read(32'd131, 32'd4, 0);
    do_read(32'hFFFF_FC81, 32'd2, 0);

    // No read request: outputs idle even on a cached address.
    @(posedge clk);
    #1 address = 32'd128;
    @(negedge clk);
    check("idle_read_data", read_data, 32'd0);
    check("idle_stall", {31'd0, stall}, 32'd0);

    // Write hit updates both cache and memory.
    do_write("wr130_hit", 32'd130, 32'd15);
    do_read(32'd130, 32'd15, 0);
    check("mem130_hit", dut.mem[130], 32'd15);

    // Reset during the third access cycle of a write aborts it.
    do_write("wr200", 32'd200, 32'hAA);
    @(posedge clk);
    #1;
    address    = 32'd200;
    write_data = 32'hBB;
    write_en   = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_neg = 1'b0;
    #1;
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_state", 32'(dut.state), 32'd0);
    check("abort_cnt", 32'(dut.cnt), 32'd0);
    write_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_neg = 1'b1;
    check("abort_mem200", dut.mem[200], 32'hAA);
    do_read(32'd128, 32'd1, 5);
    do_read(32'd130, 32'd15, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
